// File: rtl/cache_trace_feeder.sv
// Trace-entry FIFO plus issue sequencer for the cache model: holds each issued
// entry for HOLD_CYCLES and absorbs repeated addresses. Optional macro: TRACE_FEEDER_STATS_EN.
module cache_trace_feeder #(
  parameter int                ADDR_W      = 48,
  parameter int                OP_W        = 8,
  parameter int                DEPTH       = 8,
  parameter int                HOLD_CYCLES = 8,
  parameter logic [OP_W-1:0]   OP_READ     = OP_W'(8'h52),
  parameter logic [OP_W-1:0]   OP_WRITE    = OP_W'(8'h57)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [OP_W-1:0]          in_op,
  output logic [ADDR_W-1:0]        cache_addr,
  output logic [OP_W-1:0]          cache_op,
  output logic                     issue_pulse,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [11:0]              dup_count,
  output logic [11:0]              bad_op_count,
`ifdef TRACE_FEEDER_STATS_EN
  output logic [11:0]              num_issued_reads,
  output logic [11:0]              num_issued_writes,
`endif
  output logic                     dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t            state, next_state;
  logic [HW-1:0]     hold_cnt, next_hold;
  logic [AW:0]       wptr, rptr;
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [OP_W-1:0]   mem_op   [DEPTH];
  logic [ADDR_W-1:0] head_addr;
  logic [OP_W-1:0]   head_op;
  logic              full, empty, accept, op_ok, store, reject;
  logic              pop, issue, dup;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // Handshake: an entry transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on reset and FIFO fullness, never on in_valid, so a
  // pop in the same cycle cannot make room for a push into a full FIFO.
  assign full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign empty    = (wptr == rptr);
  assign in_ready = reset & ~full;
  assign accept   = in_valid & in_ready;
  assign op_ok    = (in_op == OP_READ) || (in_op == OP_WRITE);
  assign store    = accept & op_ok;
  assign reject   = accept & ~op_ok;

  assign head_addr  = mem_addr[rptr[AW-1:0]];
  assign head_op    = mem_op[rptr[AW-1:0]];
  assign fifo_count = wptr - rptr;
  assign busy       = (state != IDLE) || !empty;
  assign dbg_state  = (state == HOLD);

  always_ff @(posedge clk) begin
    if (store) begin
      mem_addr[wptr[AW-1:0]] <= in_addr;
      mem_op[wptr[AW-1:0]]   <= in_op;
    end
  end

  // The cache only sees a new request when the address changes, so a head
  // matching the presented address is popped and counted instead of issued.
  always_comb begin
    next_state = state;
    next_hold  = hold_cnt;
    pop        = 1'b0;
    issue      = 1'b0;
    dup        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_addr == cache_addr) begin
            dup = 1'b1;
          end else begin
            issue      = 1'b1;
            next_hold  = HOLD_LOAD;
            next_state = HOLD;
          end
        end
      end
      HOLD: begin
        if (hold_cnt == '0) next_state = IDLE;
        else                next_hold  = hold_cnt - 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      wptr         <= '0;
      rptr         <= '0;
      cache_addr   <= '0;
      cache_op     <= '0;
      issue_pulse  <= 1'b0;
      dup_count    <= '0;
      bad_op_count <= '0;
    end else begin
      state       <= next_state;
      hold_cnt    <= next_hold;
      issue_pulse <= issue;
      if (store) wptr <= wptr + PTR_ONE;
      if (pop)   rptr <= rptr + PTR_ONE;
      if (issue) begin
        cache_addr <= head_addr;
        cache_op   <= head_op;
      end
      if (dup)    dup_count    <= sat_inc(dup_count);
      if (reject) bad_op_count <= sat_inc(bad_op_count);
    end
  end

`ifdef TRACE_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_issued_reads  <= '0;
      num_issued_writes <= '0;
    end else if (issue) begin
      if (head_op == OP_READ)  num_issued_reads  <= sat_inc(num_issued_reads);
      if (head_op == OP_WRITE) num_issued_writes <= sat_inc(num_issued_writes);
    end
  end
`endif

endmodule

// File: tb/tb_cache_trace_feeder.sv
// Directed bench for cache_trace_feeder: single-entry vector table plus
// multi-cycle sequences (back-to-back, full FIFO, reset mid-hold, saturation).
module tb_cache_trace_feeder;
  localparam int ADDR_W = 48;
  localparam int DEPTH = 8;
  localparam int HOLD_CYCLES = 8;
  localparam logic [7:0] OPR = 8'h52;
  localparam logic [7:0] OPW = 8'h57;
  localparam int K_ISSUE = 0;
  localparam int K_DUP = 1;
  localparam int K_BAD = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [7:0]        in_op = '0;
  logic [ADDR_W-1:0] cache_addr;
  logic [7:0]        cache_op;
  logic              issue_pulse;
  logic              busy;
  logic [3:0]        fifo_count;
  logic [11:0]       dup_count;
  logic [11:0]       bad_op_count;
`ifdef TRACE_FEEDER_STATS_EN
  logic [11:0]       num_issued_reads;
  logic [11:0]       num_issued_writes;
`endif
  logic              dbg_state;

  cache_trace_feeder #(
    .ADDR_W(ADDR_W), .OP_W(8), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD_CYCLES),
    .OP_READ(OPR), .OP_WRITE(OPW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_op(in_op), .cache_addr(cache_addr), .cache_op(cache_op),
    .issue_pulse(issue_pulse), .busy(busy), .fifo_count(fifo_count),
    .dup_count(dup_count), .bad_op_count(bad_op_count),
`ifdef TRACE_FEEDER_STATS_EN
    .num_issued_reads(num_issued_reads), .num_issued_writes(num_issued_writes),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [55:0] exp_q[$];
  int issue_times[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: every issue must match the front of the expected queue
  always @(negedge clk) begin
    if (reset === 1'b1 && issue_pulse === 1'b1) begin
      issue_times.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_issue: got addr=0x%0h op=0x%0h expected none", cache_addr, cache_op);
      end else begin
        logic [55:0] e;
        e = exp_q.pop_front();
        if ({cache_addr, cache_op} !== e) begin
          bad++;
          $display("FAIL issue_value: got 0x%0h expected 0x%0h", {cache_addr, cache_op}, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks (called at a negedge, return at the negedge after the push edge)
  task automatic drive(input logic [ADDR_W-1:0] a, input logic [7:0] o);
    in_addr  = a;
    in_op    = o;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int limit, output int waited);
    waited = -1;
    for (int s = 0; s < limit; s++) begin
      if (!busy) begin
        waited = s;
        return;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        op;
    int                kind;
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        exp_op;
    logic [11:0]       exp_dup;
    logic [11:0]       exp_bad;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int waited, pulses, first_at, idle_at, exp_idle, min_gap;
    logic unstable, ready_ok;

    vecs[0] = '{48'h0,            OPR,   K_DUP,   48'h0,            8'h00, 12'd1, 12'd0};
    vecs[1] = '{48'h1000,         OPR,   K_ISSUE, 48'h1000,         OPR,   12'd1, 12'd0};
    vecs[2] = '{48'h1000,         OPW,   K_DUP,   48'h1000,         OPR,   12'd2, 12'd0};
    vecs[3] = '{48'h2000,         OPW,   K_ISSUE, 48'h2000,         OPW,   12'd2, 12'd0};
    vecs[4] = '{48'h3000,         8'h58, K_BAD,   48'h2000,         OPW,   12'd2, 12'd1};
    vecs[5] = '{48'hFFFFFFFFFFFF, OPR,   K_ISSUE, 48'hFFFFFFFFFFFF, OPR,   12'd2, 12'd1};
    vecs[6] = '{48'h0,            OPW,   K_ISSUE, 48'h0,            OPW,   12'd2, 12'd1};
    vecs[7] = '{48'h1,            8'h72, K_BAD,   48'h0,            OPW,   12'd2, 12'd2};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_cache_addr", cache_addr, 0);
    check("rst_cache_op", cache_op, 0);
    check("rst_issue_pulse", issue_pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_dup_count", dup_count, 0);
    check("rst_bad_op_count", bad_op_count, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);

    // vector table: one entry pushed into an idle feeder per record
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].kind == K_ISSUE) exp_q.push_back({vecs[i].addr, vecs[i].op});
      drive(vecs[i].addr, vecs[i].op);
      in_valid = 1'b0;
      check($sformatf("v%0d_fifo_count", i), fifo_count, (vecs[i].kind == K_BAD) ? 0 : 1);
      pulses = 0; first_at = -1; idle_at = -1; unstable = 1'b0;
      for (int s = 0; s < 40; s++) begin
        if (issue_pulse) begin
          pulses++;
          if (first_at < 0) first_at = s;
        end
        if (pulses > 0 && (cache_addr !== vecs[i].exp_addr || cache_op !== vecs[i].exp_op))
          unstable = 1'b1;
        if (!busy) begin
          idle_at = s;
          break;
        end
        @(negedge clk);
      end
      exp_idle = (vecs[i].kind == K_ISSUE) ? HOLD_CYCLES + 1 : (vecs[i].kind == K_DUP) ? 1 : 0;
      check($sformatf("v%0d_idle_at", i), idle_at, exp_idle);
      check($sformatf("v%0d_pulses", i), pulses, (vecs[i].kind == K_ISSUE) ? 1 : 0);
      if (vecs[i].kind == K_ISSUE) check($sformatf("v%0d_latency", i), first_at, 1);
      check($sformatf("v%0d_stable", i), unstable, 0);
      check($sformatf("v%0d_cache_addr", i), cache_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_cache_op", i), cache_op, vecs[i].exp_op);
      check($sformatf("v%0d_dup_count", i), dup_count, vecs[i].exp_dup);
      check($sformatf("v%0d_bad_op_count", i), bad_op_count, vecs[i].exp_bad);
    end

    // back-to-back with a duplicate in the middle
    issue_times.delete();
    exp_q.push_back({48'h40, OPW});
    exp_q.push_back({48'h80, OPR});
    drive(48'h40, OPW);
    drive(48'h40, OPR);
    drive(48'h80, OPR);
    in_valid = 1'b0;
    wait_idle(60, waited);
    check("b2b_idle", waited >= 0, 1);
    check("b2b_issues", issue_times.size(), 2);
    if (issue_times.size() == 2) check("b2b_gap_ge9", (issue_times[1] - issue_times[0]) >= 9, 1);
    check("b2b_dup_count", dup_count, 3);
    check("b2b_cache_addr", cache_addr, 48'h80);
    check("b2b_cache_op", cache_op, OPR);

    // fill the FIFO while the first entry is held
    issue_times.delete();
    exp_q.push_back({48'h100, OPW});
    drive(48'h100, OPW);
    ready_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ready_ok = ready_ok & in_ready;
      exp_q.push_back({48'h200 + 48'(k * 16), OPR});
      drive(48'h200 + 48'(k * 16), OPR);
      if (k == 0) check("full_push_pop_count", fifo_count, 1);
    end
    check("full_ready_before", ready_ok, 1);
    check("full_count8", fifo_count, 8);
    check("full_in_ready0", in_ready, 0);
    in_addr = 48'h999;
    in_op   = OPR;
    @(negedge clk);
    check("full_refused_count", fifo_count, 8);
    check("full_refused_ready", in_ready, 0);
    @(negedge clk);
    check("full_pop_count", fifo_count, 7);
    check("full_ready_after_pop", in_ready, 1);
    in_valid = 1'b0;
    wait_idle(150, waited);
    check("full_idle", waited >= 0, 1);
    check("full_issues", issue_times.size(), 9);
    min_gap = 1000;
    for (int j = 1; j < issue_times.size(); j++)
      if (issue_times[j] - issue_times[j-1] < min_gap) min_gap = issue_times[j] - issue_times[j-1];
    check("full_min_gap_ge9", min_gap >= 9, 1);
    check("full_last_addr", cache_addr, 48'h270);

    // reset mid-hold with three queued entries
    issue_times.delete();
    exp_q.push_back({48'h500, OPR});
    drive(48'h500, OPR);
    drive(48'h510, OPR);
    drive(48'h520, OPW);
    drive(48'h530, OPR);
    in_valid = 1'b0;
    check("mid_fifo_count", fifo_count, 3);
    check("mid_in_hold", dbg_state, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_cache_addr", cache_addr, 0);
    check("arst_cache_op", cache_op, 0);
    check("arst_issue_pulse", issue_pulse, 0);
    check("arst_busy", busy, 0);
    check("arst_fifo_count", fifo_count, 0);
    check("arst_dup_count", dup_count, 0);
    check("arst_bad_op_count", bad_op_count, 0);
    check("arst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_no_issue", issue_times.size(), 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_addr", cache_addr, 0);

    // mixed reads and writes after reset
    issue_times.delete();
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({48'h701 + 48'(k), (k % 2 == 0) ? OPR : OPW});
      drive(48'h701 + 48'(k), (k % 2 == 0) ? OPR : OPW);
    end
    in_valid = 1'b0;
    wait_idle(100, waited);
    check("mix_idle", waited >= 0, 1);
    check("mix_issues", issue_times.size(), 5);
    check("mix_last_addr", cache_addr, 48'h705);
    check("mix_last_op", cache_op, OPR);
    check("mix_dup_count", dup_count, 0);
`ifdef TRACE_FEEDER_STATS_EN
    check("stats_reads", num_issued_reads, 3);
    check("stats_writes", num_issued_writes, 2);
`endif

    // bad-op counter saturation
    in_addr  = '0;
    in_op    = 8'h00;
    in_valid = 1'b1;
    repeat (4100) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("sat_bad_op_count", bad_op_count, 12'hFFF);
    check("sat_fifo_count", fifo_count, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
